// File: rtl/mem_arb_pkg.sv
// Shared types and default burst geometry for the RAM port arbiter.
package mem_arb_pkg;
    localparam int MEM_WORD_DEF   = 32;
    localparam int BLOCK_BITS_DEF = 512;
    localparam int BEATS          = BLOCK_BITS_DEF / MEM_WORD_DEF;
    localparam int BEAT_W         = $clog2(BEATS);
    localparam int BLK_OFF_W      = $clog2(BLOCK_BITS_DEF / 8);

    typedef enum logic {IDLE, BURST} state_t;
    typedef enum logic {OWN_IC, OWN_DC} owner_t;
endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker; the last-grant history lives in the parent.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_grant,
    output owner_t     grant,
    output logic       valid
);
    always_comb begin
        valid = |req;
        grant = OWN_IC;
        case (req)
            2'b01:   grant = OWN_IC;
            2'b10:   grant = OWN_DC;
            2'b11:   grant = (last_grant == OWN_DC) ? OWN_IC : OWN_DC;
            default: grant = OWN_IC;
        endcase
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Grants the single RAM port to the I-cache or D-cache for one whole block burst.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_WORD   = 32,
    parameter int ADDR_W     = 32,
    parameter int BLOCK_BITS = 512
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                ic_req,
    input  logic [ADDR_W-1:0]   ic_addr,
    output logic [MEM_WORD-1:0] ic_rdata,
    output logic                ic_valid,
    output logic                ic_done,
    input  logic                dc_req,
    input  logic                dc_we,
    input  logic [ADDR_W-1:0]   dc_addr,
    input  logic [MEM_WORD-1:0] dc_wdata,
    output logic [MEM_WORD-1:0] dc_rdata,
    output logic                dc_valid,
    output logic                dc_done,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [MEM_WORD-1:0] mem_wdata,
    input  logic [MEM_WORD-1:0] mem_rdata,
    input  logic                mem_ready
);
    localparam int N_BEATS = BLOCK_BITS / MEM_WORD;
    localparam int CNT_W   = $clog2(N_BEATS);
    localparam int OFF_W   = $clog2(BLOCK_BITS / 8);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(N_BEATS - 1);

    state_t            state, state_nxt;
    owner_t            owner, last_grant, rr_grant;
    logic              rr_valid;
    logic [CNT_W-1:0]  beat_cnt;
    logic              in_burst, beat_last, ic_own, dc_own;
    logic [ADDR_W-1:0] sel_addr;

    mem_arb_rr u_rr (
        .req        ({dc_req, ic_req}),
        .last_grant (last_grant),
        .grant      (rr_grant),
        .valid      (rr_valid)
    );

    assign in_burst  = (state == BURST);
    assign beat_last = (beat_cnt == LAST_BEAT);
    assign ic_own    = (owner == OWN_IC);
    assign dc_own    = (owner == OWN_DC);
    assign sel_addr  = (rr_grant == OWN_DC) ? dc_addr : ic_addr;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rr_valid) state_nxt = BURST;
            BURST:   if (mem_ready && beat_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= IDLE;
            owner      <= OWN_IC;
            last_grant <= OWN_DC;
            beat_cnt   <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && rr_valid) begin
                owner    <= rr_grant;
                mem_addr <= sel_addr & ~OFF_MASK;
                mem_we   <= (rr_grant == OWN_DC) ? dc_we : 1'b0;
                beat_cnt <= '0;
            end else if (in_burst && mem_ready) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
                if (beat_last) last_grant <= owner;
            end
        end
    end

    // Strobes are combinational with mem_ready so beats carry no extra latency.
    assign mem_req   = in_burst;
    assign ic_rdata  = mem_rdata;
    assign dc_rdata  = mem_rdata;
    assign ic_valid  = mem_ready & in_burst & ic_own;
    assign dc_valid  = mem_ready & in_burst & dc_own;
    assign ic_done   = ic_valid & beat_last;
    assign dc_done   = dc_valid & beat_last;
    assign mem_wdata = (dc_own && mem_we) ? dc_wdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a burst-level reference model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        nrst;
    logic        ic_req, dc_req, dc_we, mem_ready;
    logic [31:0] ic_addr, dc_addr, dc_wdata, mem_rdata;
    logic [31:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;
    logic        ic_valid, ic_done, dc_valid, dc_done, mem_req, mem_we;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_WORD(32), .ADDR_W(32), .BLOCK_BITS(512)) dut (
        .clk(clk), .nrst(nrst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_valid(ic_valid), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_valid(dc_valid), .dc_done(dc_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns the port, how many beats have moved, and the burst attributes.
    bit          m_busy = 0;
    bit          m_own  = 0;   // 0 = I-cache, 1 = D-cache
    bit          m_last = 1;
    bit          m_we   = 0;
    int          m_beats = 0;
    logic [31:0] m_addr = '0;

    bit auto_drop_ic = 0, auto_drop_dc = 0;
    int rdy_mode = 0;
    int cyc = 0;
    int ic_beats_seen = 0, dc_beats_seen = 0, dones_seen = 0;
    int grant_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit e_icv, e_dcv, e_icd, e_dcd;
        logic [31:0] e_wd;
        case (rdy_mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = (cyc % 3 == 2);
            default: mem_ready = 1'($urandom_range(0, 1));
        endcase
        mem_rdata = $urandom;
        @(negedge clk);
        e_icv = m_busy && mem_ready && !m_own;
        e_dcv = m_busy && mem_ready && m_own;
        e_icd = e_icv && (m_beats == BEATS - 1);
        e_dcd = e_dcv && (m_beats == BEATS - 1);
        e_wd  = (m_own && m_we) ? dc_wdata : 32'd0;
        chk("mem_req",   32'(mem_req),  32'(m_busy));
        chk("mem_we",    32'(mem_we),   32'(m_we));
        chk("mem_addr",  mem_addr,      m_addr);
        chk("mem_wdata", mem_wdata,     e_wd);
        chk("ic_valid",  32'(ic_valid), 32'(e_icv));
        chk("dc_valid",  32'(dc_valid), 32'(e_dcv));
        chk("ic_done",   32'(ic_done),  32'(e_icd));
        chk("dc_done",   32'(dc_done),  32'(e_dcd));
        chk("ic_rdata",  ic_rdata,      mem_rdata);
        chk("dc_rdata",  dc_rdata,      mem_rdata);
        if (ic_valid === 1'b1) ic_beats_seen++;
        if (dc_valid === 1'b1) dc_beats_seen++;
        if (ic_done === 1'b1) begin dones_seen++; grant_log.push_back(0); end
        if (dc_done === 1'b1) begin dones_seen++; grant_log.push_back(1); end
        @(posedge clk);
        if (!nrst) begin
            m_busy = 0; m_own = 0; m_last = 1; m_we = 0; m_addr = '0; m_beats = 0;
        end else if (!m_busy) begin
            if (ic_req || dc_req) begin
                m_own   = (ic_req && dc_req) ? !m_last : dc_req;
                m_addr  = ((m_own ? dc_addr : ic_addr) / (BLOCK_BITS_DEF / 8)) * (BLOCK_BITS_DEF / 8);
                m_we    = m_own ? dc_we : 1'b0;
                m_beats = 0;
                m_busy  = 1;
            end
        end else if (mem_ready) begin
            m_beats++;
            if (m_beats == BEATS) begin
                m_busy = 0;
                m_last = m_own;
            end
        end
        #1;
        cyc++;
        if (e_dcv) dc_wdata = dc_wdata + 32'd1;
        if (auto_drop_ic && e_icd) ic_req = 1'b0;
        if (auto_drop_dc && e_dcd) dc_req = 1'b0;
    endtask

    task automatic clear_counts();
        ic_beats_seen = 0; dc_beats_seen = 0; dones_seen = 0;
        grant_log.delete();
    endtask

    initial begin
        nrst = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) cycle();
        nrst = 1'b1;
        cycle();

        // I-cache alone, ready every cycle
        clear_counts();
        ic_addr = 32'h0000_1234; ic_req = 1'b1; auto_drop_ic = 1;
        repeat (20) cycle();
        chk("ic_only_beats", 32'(ic_beats_seen), 32'd16);
        chk("ic_only_dones", 32'(dones_seen), 32'd1);
        chk("ic_only_addr",  mem_addr, 32'h0000_1200);

        // Simultaneous requests straight out of reset: I-cache first
        nrst = 1'b0; repeat (2) cycle(); nrst = 1'b1;
        clear_counts();
        ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b0; dc_addr = $urandom; auto_drop_dc = 1;
        repeat (40) cycle();
        chk("tie_bursts", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            chk("tie_first",  32'(grant_log[0]), 32'd0);
            chk("tie_second", 32'(grant_log[1]), 32'd1);
        end

        // D-cache writeback with incrementing write data
        clear_counts();
        dc_we = 1'b1; dc_addr = 32'h8000_0040; dc_wdata = '0; dc_req = 1'b1;
        repeat (20) cycle();
        chk("wb_beats", 32'(dc_beats_seen), 32'd16);
        chk("wb_addr",  mem_addr, 32'h8000_0040);
        chk("wb_we",    32'(mem_we), 32'd1);

        // Gapped ready: one beat every third cycle
        clear_counts();
        rdy_mode = 1; ic_addr = $urandom; ic_req = 1'b1;
        repeat (55) cycle();
        chk("gap_beats", 32'(ic_beats_seen), 32'd16);
        chk("gap_dones", 32'(dones_seen), 32'd1);
        rdy_mode = 0;

        // D-cache drops its request after beat 5
        clear_counts();
        dc_we = 1'b0; dc_addr = $urandom; dc_req = 1'b1; auto_drop_dc = 0;
        for (int i = 0; i < 20 && dc_beats_seen < 5; i++) cycle();
        chk("drop_reach5", 32'(dc_beats_seen), 32'd5);
        dc_req = 1'b0;
        repeat (20) cycle();
        chk("drop_beats", 32'(dc_beats_seen), 32'd16);
        chk("drop_dones", 32'(dones_seen), 32'd1);

        // Reset lands mid-burst after beat 7
        clear_counts();
        ic_addr = $urandom; ic_req = 1'b1; auto_drop_ic = 0;
        for (int i = 0; i < 20 && ic_beats_seen < 7; i++) cycle();
        chk("rst_reach7", 32'(ic_beats_seen), 32'd7);
        ic_req = 1'b0; nrst = 1'b0;
        cycle();
        nrst = 1'b1;
        repeat (3) cycle();
        chk("rst_no_done", 32'(dones_seen), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);

        // Both requests held: grants alternate over four bursts
        clear_counts();
        ic_req = 1'b1; dc_req = 1'b1;
        for (int i = 0; i < 120 && grant_log.size() < 4; i++) cycle();
        ic_req = 1'b0; dc_req = 1'b0;
        chk("fair_bursts", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk("fair_order", 32'(grant_log[i]), 32'(i % 2));
        repeat (20) cycle();

        // Random traffic with random ready
        rdy_mode = 2; auto_drop_ic = 1; auto_drop_dc = 1;
        for (int i = 0; i < 400; i++) begin
            if (!ic_req && $urandom_range(0, 3) == 0) begin
                ic_req = 1'b1; ic_addr = $urandom;
            end
            if (!dc_req && $urandom_range(0, 3) == 0) begin
                dc_req = 1'b1; dc_addr = $urandom; dc_we = 1'($urandom_range(0, 1));
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
